cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits directly downstream of the CPU-plus-cache top level, on its pmem port.
- Converts each 256-bit cacheline read or write into a 4-beat, 64-bit burst on the physical DRAM interface.
- Buffers the line for each transfer and returns a single-cycle pmem_resp when the burst completes.
- One transaction is handled at a time; there is no queueing.

Parameters:
- LINE_WIDTH, 256: cacheline width in bits, matching pmem_rdata/pmem_wdata.
- BURST_WIDTH, 64: DRAM beat width in bits.
- BEATS, LINE_WIDTH/BURST_WIDTH (=4): derived; beats per line. Must be a power of two.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pmem_read  in  1  line read request; held by the cache until pmem_resp.
- pmem_write  in  1  line write request; held by the cache until pmem_resp.
- pmem_address  in  32  line address; bits [4:0] are ignored.
- pmem_wdata  in  256  write line.
- pmem_rdata  out  256  read line; valid in the pmem_resp cycle.
- pmem_resp  out  1  one-cycle completion pulse.
- mem_read  out  1  DRAM burst read; held until the last beat.
- mem_write  out  1  DRAM burst write; held until the last beat.
- mem_address  out  32  burst address, {latched addr[31:5], 5'b0}.
- mem_wdata  out  64  current write beat.
- mem_rdata  in  64  current read beat.
- mem_resp  in  1  beat handshake; one beat transfers per cycle it is high.

Behaviour:
- States: IDLE, READ, WRITE, DONE. The beat counter is 2 bits (log2 BEATS).
- Reset values: state IDLE, counter 0, and all outputs 0 (pmem_rdata, pmem_resp, mem_read, mem_write, mem_address, mem_wdata).
- IDLE:
  - On pmem_write: latch pmem_address and pmem_wdata, go to WRITE.
  - Else on pmem_read: latch pmem_address, go to READ.
  - pmem_write has priority when both are high; pmem_read stays pending.
  - Requests are sampled only in IDLE; pmem_* input changes during a burst are ignored.
- READ:
  - mem_read=1 and mem_address driven.
  - Each cycle with mem_resp=1: buffer[64*k +: 64] <= mem_rdata, k = counter, counter++.
  - Cycles with mem_resp=0 are stalls; nothing changes.
  - When the beat with k=3 is accepted, go to DONE; mem_read drops in the DONE cycle.
- WRITE:
  - mem_write=1, mem_wdata = latched_wdata[64*k +: 64] (combinational from the counter).
  - Advances on mem_resp exactly as READ; after beat 3, go to DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle; pmem_rdata = buffer (read case).
  - Counter is cleared; return to IDLE unconditionally.
  - The request is not re-sampled in DONE, so a held pmem_read cannot launch a duplicate burst.
- pmem_rdata holds its value until the next read's first beat overwrites it. It is meaningful only in the pmem_resp cycle.
- Minimum latency with zero-wait DRAM (mem_resp high every cycle):
  - Request seen in cycle 0; beats in cycles 1-4; pmem_resp in cycle 5.
  - The earliest next request is accepted in cycle 6.
- A mem_resp seen in IDLE or DONE is ignored.
- Counter wraps 3->0 only via DONE; no partial lines are ever returned.
- rst during any state: next cycle is IDLE with all outputs 0. The in-flight burst is abandoned, no pmem_resp is issued, and the cache must re-request.
- Beat order is little-endian: beat 0 maps to line bits [63:0], beat 3 to [255:192].

Test Plan:
- Read, zero-wait: pmem_read, addr 0x0000_1234; DRAM returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back.
  - Expect mem_address=0x0000_1220, mem_read high in cycles 1-4.
  - Expect pmem_resp in cycle 5 only, with pmem_rdata={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write: pmem_write, addr 0x8000_00E0, wdata = 64-bit words D3|D2|D1|D0.
  - Expect mem_wdata=D0,D1,D2,D3 on successive mem_resp cycles and mem_write high throughout.
  - Expect a single pmem_resp one cycle after beat 3.
- Stalled read: mem_resp pattern 1,0,0,1,0,1,1.
  - Expect the counter to advance only on 1s and mem_read held through the gaps.
  - Expect pmem_resp exactly one cycle after the 4th accepted beat, with correct data.
- Simultaneous pmem_read and pmem_write in IDLE.
  - Expect the write burst first, then the pending read starts on the IDLE cycle after DONE.
  - Expect two pmem_resp pulses total.
- Reset mid-burst: assert rst after 2 read beats.
  - Expect all outputs 0 the next cycle and no pmem_resp.
  - A fresh read then completes with all 4 new beats and no stale data from before reset.
- Held request: keep pmem_read high for 3 cycles after pmem_resp.
  - Expect a second burst to start only from IDLE (one cycle after DONE), never a resp without a burst.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Purpose : bridges a 256-bit cacheline pmem port onto a 4-beat x 64-bit DRAM burst port.
// Latency : request sampled in IDLE, beats follow from the next cycle, pmem_resp one cycle after the last beat.
// Backpressure: DRAM stalls by holding mem_resp low; the cache holds pmem_read/pmem_write until pmem_resp.
//
// Ports:
//   clk, rst                 single rising-edge clock, synchronous active-high reset
//   pmem_read/pmem_write     line requests from the cache (write wins if both are high)
//   pmem_address/pmem_wdata  line address (offset bits ignored) and write line
//   pmem_rdata/pmem_resp     read line and one-cycle completion pulse
//   mem_read/mem_write       DRAM burst strobes, held for the whole burst
//   mem_address              line-aligned burst address
//   mem_wdata/mem_rdata      current write/read beat
//   mem_resp                 DRAM beat handshake, one beat per high cycle
module cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [31:0]            pmem_address,
    input  logic [LINE_WIDTH-1:0]  pmem_wdata,
    output logic [LINE_WIDTH-1:0]  pmem_rdata,
    output logic                   pmem_resp,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [31:0]            mem_address,
    output logic [BURST_WIDTH-1:0] mem_wdata,
    input  logic [BURST_WIDTH-1:0] mem_rdata,
    input  logic                   mem_resp
);

    localparam int BEATS    = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        beat_cnt;
    logic [LINE_WIDTH-1:0]   wdata_q;

    // Offset bits inside the line never reach DRAM; bursts are always line aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^pmem_address[OFFSET_W-1:0];

    // Read beats land directly in pmem_rdata, so it doubles as the line buffer and
    // keeps the previous line until the next read's first beat overwrites slice 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            wdata_q     <= '0;
            pmem_rdata  <= '0;
            pmem_resp   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pmem_write) begin
                        mem_address <= {pmem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
                        wdata_q     <= pmem_wdata;
                        mem_write   <= 1'b1;
                        state       <= WRITE;
                    end else if (pmem_read) begin
                        mem_address <= {pmem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
                        mem_read    <= 1'b1;
                        state       <= READ;
                    end
                end

                READ: begin
                    if (mem_resp) begin
                        pmem_rdata[int'(beat_cnt) * BURST_WIDTH +: BURST_WIDTH] <= mem_rdata;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            mem_read  <= 1'b0;
                            pmem_resp <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                WRITE: begin
                    if (mem_resp) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            mem_write <= 1'b0;
                            pmem_resp <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                DONE: begin
                    // No request sampling here: a request still held from the
                    // finished transaction must not launch a duplicate burst.
                    pmem_resp <= 1'b0;
                    beat_cnt  <= '0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Write beat follows the counter combinationally so each mem_resp advances to the next slice.
    always_comb begin
        mem_wdata = '0;
        if (state == WRITE) begin
            mem_wdata = wdata_q[int'(beat_cnt) * BURST_WIDTH +: BURST_WIDTH];
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;

    int checks   = 0;
    int errors   = 0;
    int resp_cnt = 0;
    int r0;
    int b;

    cacheline_adaptor #(.LINE_WIDTH(256), .BURST_WIDTH(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    always #5 clk = ~clk;

    // Completion pulses are counted mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (pmem_resp === 1'b1) resp_cnt++;
    end

    localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

    function automatic logic [63:0] beat(input logic [7:0] v);
        return {8{v}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chkw({tag, "_pmem_rdata"}, pmem_rdata, 256'(0));
        chk1({tag, "_pmem_resp"}, pmem_resp, 1'b0);
        chk1({tag, "_mem_read"}, mem_read, 1'b0);
        chk1({tag, "_mem_write"}, mem_write, 1'b0);
        chkw({tag, "_mem_address"}, 256'(mem_address), 256'(0));
        chkw({tag, "_mem_wdata"}, 256'(mem_wdata), 256'(0));
    endtask

    // Four zero-wait read beats; on return the bench sits in the cycle after the last beat.
    task automatic read_beats(input string tag, input logic [7:0] v0, input logic [7:0] v1,
                              input logic [7:0] v2, input logic [7:0] v3);
        logic [7:0] v [4];
        v = '{v0, v1, v2, v3};
        for (int k = 0; k < 4; k++) begin
            chk1({tag, "_mem_read"}, mem_read, 1'b1);
            chk1({tag, "_resp_early"}, pmem_resp, 1'b0);
            mem_resp  = 1'b1;
            mem_rdata = beat(v[k]);
            tick();
        end
        mem_resp  = 1'b0;
        mem_rdata = JUNK;
    endtask

    // Four zero-wait write beats, checking each beat presented to DRAM.
    task automatic write_beats(input string tag, input logic [63:0] d0, input logic [63:0] d1,
                               input logic [63:0] d2, input logic [63:0] d3);
        logic [63:0] d [4];
        d = '{d0, d1, d2, d3};
        for (int k = 0; k < 4; k++) begin
            chk1({tag, "_mem_write"}, mem_write, 1'b1);
            chk1({tag, "_mem_read"}, mem_read, 1'b0);
            chk1({tag, "_resp_early"}, pmem_resp, 1'b0);
            chkw({tag, "_mem_wdata"}, 256'(mem_wdata), 256'(d[k]));
            mem_resp = 1'b1;
            tick();
        end
        mem_resp = 1'b0;
    endtask

    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] D2 = 64'hA5A5_0000_5A5A_FFFF;
    localparam logic [63:0] D3 = 64'h0F0F_1234_F0F0_5678;

    initial begin
        rst          = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        mem_rdata    = '0;
        mem_resp     = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Zero-wait read; offset bits 0x14 must be stripped from the burst address.
        r0 = resp_cnt;
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_1234;
        tick();
        chkw("rd_addr", 256'(mem_address), 256'(32'h0000_1220));
        read_beats("rd", 8'h11, 8'h22, 8'h33, 8'h44);
        chk1("rd_resp", pmem_resp, 1'b1);
        chk1("rd_mem_read_drop", mem_read, 1'b0);
        chkw("rd_data", pmem_rdata, {beat(8'h44), beat(8'h33), beat(8'h22), beat(8'h11)});
        pmem_read = 1'b0;
        tick();
        chk1("rd_resp_one_cycle", pmem_resp, 1'b0);
        chkw("rd_resp_count", 256'(resp_cnt - r0), 256'(1));

        // Write; pmem inputs are scrambled mid-burst and must be ignored.
        r0 = resp_cnt;
        pmem_write   = 1'b1;
        pmem_address = 32'h8000_00E0;
        pmem_wdata   = {D3, D2, D1, D0};
        tick();
        chkw("wr_addr", 256'(mem_address), 256'(32'h8000_00E0));
        pmem_address = 32'hFFFF_FFFF;
        pmem_wdata   = '1;
        write_beats("wr", D0, D1, D2, D3);
        chk1("wr_resp", pmem_resp, 1'b1);
        chk1("wr_mem_write_drop", mem_write, 1'b0);
        chkw("wr_keeps_rdata", pmem_rdata, {beat(8'h44), beat(8'h33), beat(8'h22), beat(8'h11)});
        pmem_write = 1'b0;
        tick();
        chk1("wr_resp_one_cycle", pmem_resp, 1'b0);
        chkw("wr_resp_count", 256'(resp_cnt - r0), 256'(1));

        // Stray mem_resp in IDLE must not advance anything.
        mem_resp  = 1'b1;
        mem_rdata = JUNK;
        tick();
        mem_resp = 1'b0;
        chk1("idle_resp_ignored", pmem_resp, 1'b0);
        chk1("idle_no_read", mem_read, 1'b0);
        chkw("idle_rdata_held", pmem_rdata, {beat(8'h44), beat(8'h33), beat(8'h22), beat(8'h11)});

        // Stalled read, mem_resp pattern 1,0,0,1,0,1,1; junk on mem_rdata during stalls.
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_4000;
        tick();
        b = 0;
        for (int i = 0; i < 7; i++) begin
            logic p;
            logic [7:0] sv [4];
            sv = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
            p  = (i == 0) || (i == 3) || (i == 5) || (i == 6);
            chk1("stall_mem_read", mem_read, 1'b1);
            chk1("stall_resp_early", pmem_resp, 1'b0);
            mem_resp  = p;
            mem_rdata = p ? beat(sv[b]) : JUNK;
            if (p) b++;
            tick();
        end
        mem_resp = 1'b0;
        chk1("stall_resp", pmem_resp, 1'b1);
        chk1("stall_mem_read_drop", mem_read, 1'b0);
        chkw("stall_data", pmem_rdata, {beat(8'hD4), beat(8'hC3), beat(8'hB2), beat(8'hA1)});
        pmem_read = 1'b0;
        tick();

        // Simultaneous read and write: write first, read launched from the IDLE after DONE.
        r0 = resp_cnt;
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_2000;
        pmem_wdata   = {D0, D1, D2, D3};
        tick();
        write_beats("both_wr", D3, D2, D1, D0);
        chk1("both_wr_resp", pmem_resp, 1'b1);
        chk1("both_no_read_in_done", mem_read, 1'b0);
        pmem_write = 1'b0;
        tick();
        chk1("both_idle_gap", mem_read, 1'b0);
        chk1("both_idle_no_resp", pmem_resp, 1'b0);
        tick();
        chkw("both_rd_addr", 256'(mem_address), 256'(32'h0000_2000));
        read_beats("both_rd", 8'h5A, 8'h6B, 8'h7C, 8'h8D);
        chk1("both_rd_resp", pmem_resp, 1'b1);
        chkw("both_rd_data", pmem_rdata, {beat(8'h8D), beat(8'h7C), beat(8'h6B), beat(8'h5A)});
        pmem_read = 1'b0;
        tick();
        chkw("both_resp_count", 256'(resp_cnt - r0), 256'(2));

        // Reset after two read beats: burst abandoned, no response, clean restart.
        r0 = resp_cnt;
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_3000;
        tick();
        for (int k = 0; k < 2; k++) begin
            mem_resp  = 1'b1;
            mem_rdata = beat(8'hE0 + 8'(k));
            tick();
        end
        mem_resp  = 1'b0;
        rst       = 1'b1;
        pmem_read = 1'b0;
        tick();
        rst = 1'b0;
        chk_all_zero("rst_mid");
        tick();
        chk1("rst_no_resp", pmem_resp, 1'b0);
        chk1("rst_no_read", mem_read, 1'b0);
        chkw("rst_resp_count", 256'(resp_cnt - r0), 256'(0));
        pmem_read = 1'b1;
        tick();
        read_beats("rst_new", 8'h01, 8'h02, 8'h03, 8'h04);
        chk1("rst_new_resp", pmem_resp, 1'b1);
        chkw("rst_new_data", pmem_rdata, {beat(8'h04), beat(8'h03), beat(8'h02), beat(8'h01)});
        pmem_read = 1'b0;
        tick();

        // Read held for three cycles past pmem_resp: next burst only from IDLE.
        r0 = resp_cnt;
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_5000;
        tick();
        read_beats("held1", 8'h91, 8'h92, 8'h93, 8'h94);
        chk1("held1_resp", pmem_resp, 1'b1);
        chkw("held1_data", pmem_rdata, {beat(8'h94), beat(8'h93), beat(8'h92), beat(8'h91)});
        tick();
        chk1("held_done_no_burst", mem_read, 1'b0);
        chk1("held_idle_no_resp", pmem_resp, 1'b0);
        tick();
        read_beats("held2", 8'hC1, 8'hC2, 8'hC3, 8'hC4);
        chk1("held2_resp", pmem_resp, 1'b1);
        chkw("held2_data", pmem_rdata, {beat(8'hC4), beat(8'hC3), beat(8'hC2), beat(8'hC1)});
        pmem_read = 1'b0;
        tick();
        chk1("held_end_no_resp", pmem_resp, 1'b0);
        chkw("held_resp_count", 256'(resp_cnt - r0), 256'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
